// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// The segment byte is laid out [7:0] = P,A,B,C,D,E,F,G (active-high).
package seg_pkg;

    localparam int SEG_P = 7;
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [7:0] SEG_OFF = 8'h00;
    // Digit enables are active-low; slice to the digit count in use.
    localparam logic [7:0] DIG_OFF = 8'hFF;

    localparam logic [7:0] GLYPH_0 = 8'h7E;
    localparam logic [7:0] GLYPH_1 = 8'h30;
    localparam logic [7:0] GLYPH_2 = 8'h6D;
    localparam logic [7:0] GLYPH_3 = 8'h79;
    localparam logic [7:0] GLYPH_4 = 8'h33;
    localparam logic [7:0] GLYPH_5 = 8'h5B;
    localparam logic [7:0] GLYPH_6 = 8'h5F;
    localparam logic [7:0] GLYPH_7 = 8'h70;
    localparam logic [7:0] GLYPH_8 = 8'h7F;
    localparam logic [7:0] GLYPH_9 = 8'h7B;
    localparam logic [7:0] GLYPH_A = 8'h77;
    localparam logic [7:0] GLYPH_B = 8'h1F;
    localparam logic [7:0] GLYPH_C = 8'h4E;
    localparam logic [7:0] GLYPH_D = 8'h3D;
    localparam logic [7:0] GLYPH_E = 8'h4F;
    localparam logic [7:0] GLYPH_F = 8'h47;

    // Hex nibble to glyph with the decimal point bit clear.
    function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
        logic [7:0] g;
        case (nib)
            4'h0: g = GLYPH_0;
            4'h1: g = GLYPH_1;
            4'h2: g = GLYPH_2;
            4'h3: g = GLYPH_3;
            4'h4: g = GLYPH_4;
            4'h5: g = GLYPH_5;
            4'h6: g = GLYPH_6;
            4'h7: g = GLYPH_7;
            4'h8: g = GLYPH_8;
            4'h9: g = GLYPH_9;
            4'hA: g = GLYPH_A;
            4'hB: g = GLYPH_B;
            4'hC: g = GLYPH_C;
            4'hD: g = GLYPH_D;
            4'hE: g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational segment decode for one digit slot: glyph, decimal point,
// glyph-only blanking (leading zeros) and full blanking (ghost/blink).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    input  logic       i_off,
    output logic [7:0] o_smg
);

    // Full blanking wins; glyph blanking keeps the decimal point.
    always_comb begin
        o_smg = SEG_OFF;
        if (!i_off) begin
            o_smg        = i_blank ? SEG_OFF : hex_glyph(i_nibble);
            o_smg[SEG_P] = i_dp;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: prescaler, digit pointer, ghost
// blanking, tear-free shadow load, blink and optional leading-zero blanking.
// Outputs are registered and lag the cnt/ptr state by one cycle.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIG_NUM      = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 125,
    parameter int LZB          = 0
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*DIG_NUM-1:0]   data,
    input  logic [DIG_NUM-1:0]     dp_mask,
    input  logic [DIG_NUM-1:0]     blink_mask,
    input  logic                   load,
    output logic [DIG_NUM-1:0]     dig,
    output logic [7:0]             smg,
    output logic                   frame_done
);

    localparam int PTR_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BL_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0]       r_cnt;
    logic [PTR_W-1:0]       r_ptr;
    logic [BL_W-1:0]        r_blink_cnt;
    logic                   r_blink_phase;
    logic                   r_pending;
    logic [4*DIG_NUM-1:0]   r_stg_data;
    logic [DIG_NUM-1:0]     r_stg_dp;
    logic [DIG_NUM-1:0]     r_stg_blink;
    logic [4*DIG_NUM-1:0]   r_sh_data;
    logic [DIG_NUM-1:0]     r_sh_dp;
    logic [DIG_NUM-1:0]     r_sh_blink;
    logic                   r_wrap;
    logic [DIG_NUM-1:0]     r_dig;
    logic [7:0]             r_smg;
    logic                   r_frame_done;

    logic                   w_slot_end;
    logic                   w_frame_end;
    logic                   w_in_blank;
    logic                   w_blinked;
    logic [DIG_NUM-1:0]     w_onehot;
    logic [DIG_NUM-1:0]     w_lead_zero;
    logic                   w_glyph_blank;
    logic [3:0]             w_nibble;
    logic [7:0]             w_smg;

    assign w_slot_end  = (r_cnt == CNT_W'(SCAN_DIV - 1));
    assign w_frame_end = w_slot_end && (r_ptr == PTR_W'(DIG_NUM - 1));

    // Prescaler and digit pointer; the pointer steps once per slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ptr <= '0;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            r_ptr <= w_frame_end ? '0 : r_ptr + PTR_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Loads are staged and only reach the shadow at a frame boundary, so a
    // frame never mixes two loads. A load on the boundary itself goes
    // straight through.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending   <= 1'b0;
            r_stg_data  <= '0;
            r_stg_dp    <= '0;
            r_stg_blink <= '0;
            r_sh_data   <= '0;
            r_sh_dp     <= '0;
            r_sh_blink  <= '0;
        end else begin
            if (load) begin
                r_stg_data  <= data;
                r_stg_dp    <= dp_mask;
                r_stg_blink <= blink_mask;
            end
            if (w_frame_end) begin
                r_pending <= 1'b0;
                if (load) begin
                    r_sh_data  <= data;
                    r_sh_dp    <= dp_mask;
                    r_sh_blink <= blink_mask;
                end else if (r_pending) begin
                    r_sh_data  <= r_stg_data;
                    r_sh_dp    <= r_stg_dp;
                    r_sh_blink <= r_stg_blink;
                end
            end else if (load) begin
                r_pending <= 1'b1;
            end
        end
    end

    // Blink phase flips every BLINK_FRAMES frame boundaries; 1 = visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (w_frame_end) begin
            if (r_blink_cnt == BL_W'(BLINK_FRAMES - 1)) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BL_W'(1);
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero;
    // digit 0 always shows.
    always_comb begin
        logic v_run;
        v_run       = 1'b1;
        w_lead_zero = '0;
        for (int i = DIG_NUM - 1; i >= 0; i--) begin
            v_run = v_run & (r_sh_data[4*i +: 4] == 4'h0);
            if (i != 0) begin
                w_lead_zero[i] = v_run;
            end
        end
    end

    // Current slot selection: one-hot digit enable and shadow nibble.
    always_comb begin
        w_onehot        = '0;
        w_onehot[r_ptr] = 1'b1;
        w_nibble        = r_sh_data[{r_ptr, 2'b00} +: 4];
    end

    assign w_in_blank    = (r_cnt < CNT_W'(BLANK_CYC));
    assign w_blinked     = r_sh_blink[r_ptr] && !r_blink_phase;
    assign w_glyph_blank = (LZB != 0) && w_lead_zero[r_ptr];

    seg_hex_decode u_decode (
        .i_nibble (w_nibble),
        .i_dp     (r_sh_dp[r_ptr]),
        .i_blank  (w_glyph_blank),
        .i_off    (w_in_blank || w_blinked),
        .o_smg    (w_smg)
    );

    // Output registers; frame_done lines up with the first output cycle
    // of slot 0 after a wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dig        <= DIG_OFF[DIG_NUM-1:0];
            r_smg        <= SEG_OFF;
            r_wrap       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dig        <= w_in_blank ? DIG_OFF[DIG_NUM-1:0] : ~w_onehot;
            r_smg        <= w_smg;
            r_wrap       <= w_frame_end;
            r_frame_done <= r_wrap;
        end
    end

    assign dig        = r_dig;
    assign smg        = r_smg;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (LZB off/on) on shared inputs,
// a cycle-level reference model, a directed vector table and random traffic.
module tb_seg_scan_driver;

  localparam int DN    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 1;
  localparam int BLF   = 2;
  localparam int FRAME = DN * DIV;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        load;
  logic [3:0]  dig0, dig1;
  logic [7:0]  smg0, smg1;
  logic        fd0, fd1;

  seg_scan_driver #(.DIG_NUM(DN), .SCAN_DIV(DIV), .BLANK_CYC(BLANK),
                    .BLINK_FRAMES(BLF), .LZB(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .load(load), .dig(dig0), .smg(smg0),
    .frame_done(fd0));

  seg_scan_driver #(.DIG_NUM(DN), .SCAN_DIV(DIV), .BLANK_CYC(BLANK),
                    .BLINK_FRAMES(BLF), .LZB(1)) u_lzb (
    .clk(clk), .rst_n(rst_n), .data(data), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .load(load), .dig(dig1), .smg(smg1),
    .frame_done(fd1));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // reference model state
  int          m_k;
  int          m_frame;
  bit          m_pend;
  logic [15:0] m_stg_data, m_sh_data;
  logic [3:0]  m_stg_dp, m_sh_dp, m_stg_bl, m_sh_bl;
  logic [3:0]  e_dig0, e_dig1;
  logic [7:0]  e_smg0, e_smg1;
  logic        e_fd;

  typedef struct {
    int         t;
    logic [3:0] d;
    logic [7:0] s;
    bit         fd;
    bit         lz;
  } vec_t;
  vec_t tab[21];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] glyph_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
      4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
      4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
      4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
    endcase
  endfunction

  // What the pins should show for cycle k of the current reset epoch.
  function automatic logic [11:0] slot_out(input bit lzb, input int k);
    int c, p;
    bit visible;
    logic [3:0] oh;
    logic [6:0] g;
    logic [15:0] upper;
    c = k % DIV;
    p = (k / DIV) % DN;
    visible = ((m_frame / BLF) % 2) == 0;
    if (c < BLANK) return {4'hF, 8'h00};
    oh = 4'b0001 << p;
    if (m_sh_bl[p] && !visible) return {~oh, 8'h00};
    upper = m_sh_data >> (4 * p);
    g = glyph_of(upper[3:0]);
    if (lzb && p != 0 && upper == 16'h0) g = 7'h00;
    return {~oh, m_sh_dp[p], g};
  endfunction

  // Advance the model across one rising edge using the sampled inputs.
  task automatic model_edge();
    logic [11:0] o;
    if (!rst_n) begin
      e_dig0 = 4'hF; e_dig1 = 4'hF; e_smg0 = 8'h00; e_smg1 = 8'h00; e_fd = 1'b0;
      m_k = 0; m_frame = 0; m_pend = 0;
      m_stg_data = '0; m_stg_dp = '0; m_stg_bl = '0;
      m_sh_data = '0; m_sh_dp = '0; m_sh_bl = '0;
    end else begin
      o = slot_out(1'b0, m_k); e_dig0 = o[11:8]; e_smg0 = o[7:0];
      o = slot_out(1'b1, m_k); e_dig1 = o[11:8]; e_smg1 = o[7:0];
      e_fd = (m_k > 0) && (m_k % FRAME == 0);
      if (load) begin
        m_stg_data = data; m_stg_dp = dp_mask; m_stg_bl = blink_mask; m_pend = 1;
      end
      if (m_k % FRAME == FRAME - 1) begin
        if (m_pend) begin
          m_sh_data = m_stg_data; m_sh_dp = m_stg_dp; m_sh_bl = m_stg_bl;
        end
        m_pend = 0;
        m_frame++;
      end
      m_k++;
    end
  endtask

  // driver: one clock, then compare both instances against the model
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("dig", {12'h0, dig0}, {12'h0, e_dig0});
    check("smg", {8'h0, smg0}, {8'h0, e_smg0});
    check("frame_done", {15'h0, fd0}, {15'h0, e_fd});
    check("lzb_dig", {12'h0, dig1}, {12'h0, e_dig1});
    check("lzb_smg", {8'h0, smg1}, {8'h0, e_smg1});
    check("lzb_frame_done", {15'h0, fd1}, {15'h0, e_fd});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data = d; dp_mask = dp; blink_mask = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 0;
    for (int i = 0; i < 3 * FRAME && !seen; i++) begin
      tick();
      seen = (fd0 === 1'b1);
    end
    if (!seen) check("frame_timeout", 16'h0, 16'h1);
  endtask

  // Apply table rows lo..hi; t counts cycles from a frame_done sample.
  task automatic run_table(input int lo, input int hi);
    int now;
    now = 0;
    for (int i = lo; i <= hi; i++) begin
      while (now < tab[i].t) begin tick(); now++; end
      if (tab[i].lz) begin
        check("tab_dig", {12'h0, dig1}, {12'h0, tab[i].d});
        check("tab_smg", {8'h0, smg1}, {8'h0, tab[i].s});
      end else begin
        check("tab_dig", {12'h0, dig0}, {12'h0, tab[i].d});
        check("tab_smg", {8'h0, smg0}, {8'h0, tab[i].s});
        check("tab_fd", {15'h0, fd0}, {15'h0, tab[i].fd});
      end
    end
  endtask

  initial begin
    // scan 1234, dp on digit 1
    tab[0]  = '{0,  4'hF, 8'h00, 1, 0};
    tab[1]  = '{4,  4'hE, 8'h33, 0, 0};
    tab[2]  = '{8,  4'hF, 8'h00, 0, 0};
    tab[3]  = '{12, 4'hD, 8'hF9, 0, 0};
    tab[4]  = '{20, 4'hB, 8'h6D, 0, 0};
    tab[5]  = '{28, 4'h7, 8'h30, 0, 0};
    tab[6]  = '{32, 4'hF, 8'h00, 1, 0};
    // ABCD after tear-free load
    tab[7]  = '{4,  4'hE, 8'h3D, 0, 0};
    tab[8]  = '{12, 4'hD, 8'h4E, 0, 0};
    tab[9]  = '{20, 4'hB, 8'h1F, 0, 0};
    tab[10] = '{28, 4'h7, 8'h77, 0, 0};
    // 5A5A loaded on the boundary cycle
    tab[11] = '{4,  4'hE, 8'h77, 0, 0};
    tab[12] = '{12, 4'hD, 8'h5B, 0, 0};
    // LZB 0050
    tab[13] = '{4,  4'hE, 8'h7E, 0, 1};
    tab[14] = '{12, 4'hD, 8'h5B, 0, 1};
    tab[15] = '{20, 4'hB, 8'h00, 0, 1};
    tab[16] = '{28, 4'h7, 8'h00, 0, 1};
    // LZB 0000
    tab[17] = '{4,  4'hE, 8'h7E, 0, 1};
    tab[18] = '{12, 4'hD, 8'h00, 0, 1};
    tab[19] = '{20, 4'hB, 8'h00, 0, 1};
    tab[20] = '{28, 4'h7, 8'h00, 0, 1};

    // reset held 3 cycles with load high; first frame shows '0' glyphs
    rst_n = 1'b0; load = 1'b1; data = 16'h9F3C; dp_mask = 4'hF; blink_mask = 4'h0;
    ticks(3);
    rst_n = 1'b1; load = 1'b0;
    ticks(FRAME + 4);

    // scan pattern
    do_load(16'h1234, 4'b0010, 4'b0000);
    wait_frame();
    run_table(0, 6);

    // tear-free: load mid-frame, rest of this frame keeps old values
    ticks(11);
    do_load(16'hABCD, 4'b0000, 4'b0000);
    wait_frame();
    run_table(7, 10);

    // load coinciding with the boundary: t=30 sample means next edge is the boundary
    ticks(2);
    do_load(16'h5A5A, 4'b0000, 4'b0000);
    wait_frame();
    run_table(11, 12);

    // blink on digit 2 over several blink periods
    do_load(16'h1234, 4'b0000, 4'b0100);
    ticks(6 * FRAME);

    // leading-zero blanking
    do_load(16'h0050, 4'b0000, 4'b0000);
    wait_frame();
    run_table(13, 16);
    do_load(16'h0000, 4'b0000, 4'b0000);
    wait_frame();
    run_table(17, 20);

    // reset asserted at ptr=2, cnt=5
    wait_frame();
    ticks(20);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ticks(FRAME + 2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 799) == 0) begin
        rst_n = 1'b0;
        ticks($urandom_range(1, 3));
        rst_n = 1'b1;
      end else if ($urandom_range(0, 39) == 0) begin
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
